// File: rtl/voxel_scan_pkg.sv
// Shared types and widths for the voxel frame-buffer scan path.
package voxel_scan_pkg;

    localparam int FB_ADDR_W = 13;
    localparam int FB_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        SHIFT,
        BLANK,
        LATCH
    } scan_state_t;

endpackage

// File: rtl/scan_bit_serializer.sv
// Loads one frame-buffer word and shifts it out MSB-first with a divided shift clock.
module scan_bit_serializer
    import voxel_scan_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [FB_DATA_W-1:0] data,
    output logic                 busy,
    output logic                 done,
    output logic                 sr_data,
    output logic                 sr_clk
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FB_DATA_W);

    logic [FB_DATA_W-1:0] shift_reg;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 div_end;
    logic                 last_bit;

    assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == BIT_W'(FB_DATA_W - 1));
    assign done     = busy & sr_clk & div_end & last_bit;
    assign sr_data  = shift_reg[FB_DATA_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            sr_clk    <= 1'b0;
        end else if (!busy) begin
            if (load) begin
                shift_reg <= data;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                busy      <= 1'b1;
                sr_clk    <= 1'b0;
            end
        end else if (div_end) begin
            div_cnt <= '0;
            if (!sr_clk) begin
                sr_clk <= 1'b1;
            end else begin
                // Shift only after the high phase so data is stable across the rising edge.
                sr_clk    <= 1'b0;
                shift_reg <= {shift_reg[FB_DATA_W-2:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
                if (last_bit) begin
                    busy <= 1'b0;
                end
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frame_scan_reader.sv
// Scans voxel layers out of frame-buffer port 2 into the serial LED driver chain,
// blanking the outputs around each layer latch.
module frame_scan_reader
    import voxel_scan_pkg::*;
#(
    parameter int WORDS_PER_LAYER = 512,
    parameter int NUM_LAYERS      = 16,
    parameter int CLK_DIV         = 2,
    parameter int BLANK_CYCLES    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic [FB_ADDR_W-1:0]          fb_address,
    input  logic [FB_DATA_W-1:0]          fb_readdata,
    output logic                          sr_data,
    output logic                          sr_clk,
    output logic                          sr_latch,
    output logic                          sr_oe_n,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_sel,
    output logic                          frame_done
);

    localparam int WORD_W  = $clog2(WORDS_PER_LAYER);
    localparam int LAYER_W = $clog2(NUM_LAYERS);
    localparam int BLANK_W = $clog2(BLANK_CYCLES);

    scan_state_t        state;
    scan_state_t        next_state;
    logic [WORD_W-1:0]  word_cnt;
    logic [LAYER_W-1:0] layer_cnt;
    logic [BLANK_W-1:0] blank_cnt;
    logic               word_last;
    logic               layer_last;
    logic               blank_end;
    logic               ser_load;
    logic               ser_busy;
    logic               ser_done;

    assign word_last  = (word_cnt == WORD_W'(WORDS_PER_LAYER - 1));
    assign layer_last = (layer_cnt == LAYER_W'(NUM_LAYERS - 1));
    assign blank_end  = (blank_cnt == BLANK_W'(BLANK_CYCLES - 1));
    // The load cycle is the first SHIFT cycle: its closing edge is two edges after fb_address moved.
    assign ser_load   = (state == SHIFT) && !ser_busy;

    scan_bit_serializer #(
        .CLK_DIV(CLK_DIV)
    ) u_serializer (
        .clk    (clk),
        .reset  (reset),
        .load   (ser_load),
        .data   (fb_readdata),
        .busy   (ser_busy),
        .done   (ser_done),
        .sr_data(sr_data),
        .sr_clk (sr_clk)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (enable) next_state = ADDR;
            ADDR:    next_state = WAIT;
            WAIT:    next_state = SHIFT;
            SHIFT:   if (ser_done) next_state = word_last ? BLANK : ADDR;
            BLANK:   if (blank_end) next_state = LATCH;
            LATCH:   next_state = enable ? ADDR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            layer_cnt <= '0;
            blank_cnt <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                IDLE: begin
                    word_cnt  <= '0;
                    layer_cnt <= '0;
                end
                SHIFT: if (ser_done) word_cnt <= word_last ? '0 : word_cnt + 1'b1;
                BLANK: blank_cnt <= blank_end ? '0 : blank_cnt + 1'b1;
                LATCH: layer_cnt <= (layer_last || !enable) ? '0 : layer_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_address <= '0;
            sr_latch   <= 1'b0;
            sr_oe_n    <= 1'b1;
            layer_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (state == ADDR) begin
                fb_address <= FB_ADDR_W'({layer_cnt, word_cnt});
            end
            sr_latch   <= (next_state == LATCH);
            frame_done <= (state == LATCH) && layer_last;
            if (next_state == LATCH) begin
                layer_sel <= layer_cnt;
            end
            // Outputs stay dark until a layer has actually been latched.
            if (state == LATCH && next_state == ADDR) begin
                sr_oe_n <= 1'b0;
            end else if (next_state inside {IDLE, BLANK, LATCH}) begin
                sr_oe_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_scan_reader.sv
// Scoreboard bench: stimulus pushes expected words/latches, monitors pop and compare.
module tb_frame_scan_reader;

    localparam int WPL    = 2;
    localparam int NL     = 2;
    localparam int CDIV   = 1;
    localparam int BLANK  = 2;
    localparam int CDIV_B = 3;

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
    } word_t;

    typedef struct {
        int layer;
        bit first;
        bit cont;
        bit done;
    } latch_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, reset_b, enable_b;
    logic [12:0] fb_address, fb_address_b;
    logic [15:0] fb_readdata, fb_readdata_b;
    logic        sr_data, sr_clk, sr_latch, sr_oe_n, frame_done;
    logic        sr_data_b, sr_clk_b, sr_latch_b, sr_oe_n_b, frame_done_b;
    logic [0:0]  layer_sel, layer_sel_b;

    logic [15:0] mem_a [4];
    logic [15:0] mem_b [4];
    logic [12:0] addr_q_a, addr_q_b;

    frame_scan_reader #(
        .WORDS_PER_LAYER(WPL), .NUM_LAYERS(NL), .CLK_DIV(CDIV), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fb_address(fb_address),
        .fb_readdata(fb_readdata), .sr_data(sr_data), .sr_clk(sr_clk),
        .sr_latch(sr_latch), .sr_oe_n(sr_oe_n), .layer_sel(layer_sel), .frame_done(frame_done)
    );

    frame_scan_reader #(
        .WORDS_PER_LAYER(WPL), .NUM_LAYERS(NL), .CLK_DIV(CDIV_B), .BLANK_CYCLES(BLANK)
    ) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .fb_address(fb_address_b),
        .fb_readdata(fb_readdata_b), .sr_data(sr_data_b), .sr_clk(sr_clk_b),
        .sr_latch(sr_latch_b), .sr_oe_n(sr_oe_n_b), .layer_sel(layer_sel_b), .frame_done(frame_done_b)
    );

    // Registered-address RAM; while the registered address lags fb_address the output is garbage.
    always @(posedge clk) begin
        addr_q_a <= fb_address;
        addr_q_b <= fb_address_b;
    end
    assign fb_readdata   = (addr_q_a == fb_address)   ? mem_a[addr_q_a[1:0]] : ~mem_a[addr_q_a[1:0]];
    assign fb_readdata_b = (addr_q_b == fb_address_b) ? mem_b[addr_q_b[1:0]] : ~mem_b[addr_q_b[1:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    word_t  word_q[$];
    latch_t latch_q[$];

    // ---------------- monitor for the CLK_DIV=1 instance ----------------
    int     bit_idx = 0, bits_in_layer = 0, bits_seen = 0, latch_seen = 0;
    word_t  cur;
    latch_t cur_latch;
    logic   prev_clk = 1'b0;
    logic [2:0] oe_hist = 3'b111;
    bit     post_latch = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            bit_idx       = 0;
            bits_in_layer = 0;
            prev_clk      = 1'b0;
            oe_hist       = 3'b111;
            post_latch    = 1'b0;
        end else begin
            if (post_latch) begin
                check("frame_done", frame_done, cur_latch.done);
                check("oe_after_latch", sr_oe_n, !cur_latch.cont);
                post_latch = 1'b0;
            end else begin
                check("frame_done_quiet", frame_done, 0);
            end
            if (sr_clk && !prev_clk) begin
                if (bit_idx == 0) begin
                    if (word_q.size() == 0) begin
                        check("word_q_size", word_q.size(), 1);
                        cur.addr = '1;
                        cur.data = '0;
                    end else begin
                        cur = word_q.pop_front();
                        check("fb_address", fb_address, cur.addr);
                    end
                end
                check("sr_data", sr_data, cur.data[15-bit_idx]);
                bit_idx = (bit_idx + 1) % 16;
                bits_in_layer++;
                bits_seen++;
            end
            if (sr_latch) begin
                latch_seen++;
                if (latch_q.size() == 0) begin
                    check("latch_q_size", latch_q.size(), 1);
                end else begin
                    cur_latch = latch_q.pop_front();
                    check("layer_sel", layer_sel, cur_latch.layer);
                    check("bits_per_layer", bits_in_layer, WPL * 16);
                    check("oe_during_latch", sr_oe_n, 1);
                    if (!cur_latch.first) check("oe_blank_window", {oe_hist, sr_oe_n}, 4'b0111);
                    post_latch = 1'b1;
                end
                bits_in_layer = 0;
            end
            oe_hist  = {oe_hist[1:0], sr_oe_n};
            prev_clk = sr_clk;
        end
    end

    // ---------------- monitor for the CLK_DIV=3 instance ----------------
    int   nb = 0, cyc_b = 0, last_rise_b = 0, same_b = 0, hi_b = 0, latch_b = 0, wb, bb;
    logic prev_clk_b = 1'b0, prev_data_b = 1'b0, rise_data_b = 1'b0, prev_latch_b = 1'b0;

    always @(negedge clk) begin
        cyc_b++;
        if (reset_b) begin
            same_b = 0;
        end else begin
            same_b = (sr_data_b === prev_data_b) ? same_b + 1 : 1;
            if (sr_clk_b && !prev_clk_b) begin
                wb = (nb / 16) % (WPL * NL);
                bb = nb % 16;
                check("b_sr_data", sr_data_b, mem_b[wb][15-bb]);
                if (bb == 0) check("b_fb_address", fb_address_b, wb);
                else         check("b_bit_period", cyc_b - last_rise_b, 2 * CDIV_B);
                check("b_setup_stable", same_b >= CDIV_B + 1, 1);
                last_rise_b = cyc_b;
                rise_data_b = sr_data_b;
                hi_b = 1;
                nb++;
            end else if (sr_clk_b) begin
                hi_b++;
                check("b_hold_stable", sr_data_b, rise_data_b);
            end else if (prev_clk_b) begin
                check("b_high_len", hi_b, CDIV_B);
            end
            if (sr_latch_b) begin
                check("b_layer_sel", layer_sel_b, latch_b % NL);
                check("b_oe_latch", sr_oe_n_b, 1);
                latch_b++;
            end
            if (frame_done_b) check("b_frame_done", prev_latch_b && ((latch_b - 1) % NL == NL - 1), 1);
            prev_latch_b = sr_latch_b;
        end
        prev_clk_b  = sr_clk_b;
        prev_data_b = sr_data_b;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int n);
        word_t  e;
        latch_t t;
        for (int l = 0; l < n; l++) begin
            for (int w = 0; w < WPL; w++) begin
                e.addr = 13'((l % NL) * WPL + w);
                e.data = mem_a[(l % NL) * WPL + w];
                word_q.push_back(e);
            end
            t.layer = l % NL;
            t.first = (l == 0);
            t.cont  = (l != n - 1);
            t.done  = ((l % NL) == NL - 1);
            latch_q.push_back(t);
        end
    endtask

    task automatic wait_latches(input int target, input string name);
        int guard = 0;
        while (latch_seen < target && guard < 3000) begin
            tick();
            guard++;
        end
        if (latch_seen < target) check(name, latch_seen, target);
    endtask

    task automatic wait_bits(input int target, input string name);
        int guard = 0;
        while (bits_seen < target && guard < 3000) begin
            tick();
            guard++;
        end
        if (bits_seen < target) check(name, bits_seen, target);
    endtask

    task automatic check_reset_outputs();
        check("rst_fb_address", fb_address, 0);
        check("rst_sr_data", sr_data, 0);
        check("rst_sr_clk", sr_clk, 0);
        check("rst_sr_latch", sr_latch, 0);
        check("rst_sr_oe_n", sr_oe_n, 1);
        check("rst_layer_sel", layer_sel, 0);
        check("rst_frame_done", frame_done, 0);
    endtask

    // Runs n layers from IDLE; enable is dropped somewhere inside the final layer.
    task automatic run_layers(input int n);
        int base_l, last_addr;
        push_run(n);
        base_l = latch_seen;
        enable = 1'b1;
        if (n > 1) wait_latches(base_l + n - 1, "timeout_latch_cont");
        else       wait_bits(bits_seen + 5, "timeout_bits");
        enable = 1'b0;
        wait_latches(base_l + n, "timeout_latch_final");
        repeat (4) tick();
        last_addr = ((n - 1) % NL) * WPL + WPL - 1;
        check("idle_oe", sr_oe_n, 1);
        check("idle_addr", fb_address, last_addr);
        repeat (20) tick();
        check("idle_addr_hold", fb_address, last_addr);
        check("idle_sr_clk", sr_clk, 0);
        check("word_q_drained", word_q.size(), 0);
        check("latch_q_drained", latch_q.size(), 0);
    endtask

    task automatic randomize_mem_a();
        for (int i = 0; i < 4; i++) mem_a[i] = 16'($urandom);
    endtask

    initial begin
        int guard;
        reset    = 1'b1;
        reset_b  = 1'b1;
        enable   = 1'b0;
        enable_b = 1'b0;
        mem_a[0] = 16'hA5F0;
        mem_a[1] = 16'h0001;
        mem_a[2] = 16'h8000;
        mem_a[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) mem_b[i] = 16'($urandom);
        repeat (3) tick();
        check_reset_outputs();
        reset    = 1'b0;
        reset_b  = 1'b0;
        enable_b = 1'b1;
        repeat (2) tick();

        // Two full frames of the reference pattern.
        run_layers(2 * NL);

        // Enable dropped early in layer 0: only that layer completes.
        randomize_mem_a();
        run_layers(1);

        // Reset during a high shift-clock phase, then a fresh frame from address 0.
        randomize_mem_a();
        push_run(NL);
        enable = 1'b1;
        wait_bits(bits_seen + 20, "timeout_pre_reset");
        guard = 0;
        while (!sr_clk && guard < 100) begin
            tick();
            guard++;
        end
        check("sr_clk_high_before_reset", sr_clk, 1);
        reset = 1'b1;
        tick();
        check_reset_outputs();
        word_q.delete();
        latch_q.delete();
        reset = 1'b0;
        run_layers(NL);

        // Run crossing a frame boundary into the next frame.
        randomize_mem_a();
        run_layers(NL + 1);

        check("b_bits_min", nb >= 64, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
